// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, the zero register and the hazard FSM state type.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pipe_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/load_use_cmp.sv
// Load-use comparator: flags an IF/ID source that reads the destination of a load in ID/EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller turns lu_hit into a stall.
module load_use_cmp
    import pipe_pkg::*;
(
    input  logic       mem_read_idex,
    input  logic [4:0] rt_idex,
    input  logic [4:0] rs_ifid,
    input  logic [4:0] rt_ifid,
    input  logic       uses_rt_ifid,
    output logic       lu_hit
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_dest_live;

    // $0 is hardwired, so a load "into" it never produces a real dependency.
    assign w_dest_live = (rt_idex != REG_ZERO);
    assign w_rs_match  = (rt_idex == rs_ifid);
    // rt only matters when the younger instruction actually reads it (R-type, store, branch).
    assign w_rt_match  = uses_rt_ifid & (rt_idex == rt_ifid);
    assign lu_hit      = mem_read_idex & w_dest_live & (w_rs_match | w_rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls (multi-cycle via a small FSM) and branch/jump flushes.
// Latency: outputs combinational from state and inputs; state/counter update on rising clk.
// Backpressure: drives pc_write/if_id_write low to hold the front end. Optional HAZARD_PERF_CNT_EN adds counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int STALL_CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_ifid,
    input  logic [4:0] rt_ifid,
    input  logic       uses_rt_ifid,
    input  logic       mem_read_idex,
    input  logic [4:0] rt_idex,
    input  logic       branch_idex,
    input  logic       zero_ex,
    input  logic       jump_idex,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       control_mux,
    output logic       stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    // The first bubble is issued from RUN, so STALL only covers the remaining cycles.
    localparam logic [STALL_CNT_W-1:0] LU_RELOAD = STALL_CNT_W'(LOAD_USE_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE   = STALL_CNT_W'(1);

    hz_state_t              r_state;
    hz_state_t              w_next_state;
    logic [STALL_CNT_W-1:0] r_cnt;
    logic [STALL_CNT_W-1:0] w_next_cnt;
    logic                   w_lu_hit;
    logic                   w_redirect;

    load_use_cmp u_load_use_cmp (
        .mem_read_idex (mem_read_idex),
        .rt_idex       (rt_idex),
        .rs_ifid       (rs_ifid),
        .rt_ifid       (rt_ifid),
        .uses_rt_ifid  (uses_rt_ifid),
        .lu_hit        (w_lu_hit)
    );

    assign w_redirect = jump_idex | (branch_idex & zero_ex);

    // State and stall counter register; reset abandons any stall in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and output decode; redirect outranks any stall in either state.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        control_mux  = 1'b1;

        if (!rst) begin
            // Hold the front end and keep bubbles flowing while in reset.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            control_mux  = 1'b0;
            w_next_state = HZ_RUN;
            w_next_cnt   = '0;
        end else if (w_redirect) begin
            // Squash the two younger instructions (IF/ID and the one entering ID/EX).
            if_id_flush  = 1'b1;
            control_mux  = 1'b0;
            w_next_state = HZ_RUN;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    if (w_lu_hit) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        control_mux = 1'b0;
                        if (LOAD_USE_CYCLES > 1) begin
                            w_next_state = HZ_STALL;
                            w_next_cnt   = LU_RELOAD;
                        end
                    end
                end
                HZ_STALL: begin
                    // lu_hit is ignored: the load has already moved past the bubble.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    control_mux = 1'b0;
                    if (r_cnt <= CNT_ONE) begin
                        w_next_state = HZ_RUN;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_next_state = HZ_RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    assign stall_active = ~pc_write;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    // Free-running event counters; they only count cycles outside reset and wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall_active) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (if_id_flush) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
